spi_tx_arbiter: RTL
===================

Name: spi_tx_arbiter

Overview:
- Shares one 8-bit SPI transmitter (MOSI/SCLK byte engine with `load_data`/`done_send` handshake) between NUM_REQ requesters.
- Round-robin arbitration, per-requester active-low chip select with programmable setup/hold/gap timing, multi-byte bursts.
- Adds a done-timeout watchdog.
- Sits between client FSMs and the SPI byte engine; all timing is in system-clock cycles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CS_SETUP_CYCLES, 4, cycles cs_n is low before the first spi_load of a burst (>=1).
- CS_HOLD_CYCLES, 4, cycles cs_n stays low after the final byte completes (>=1).
- GAP_CYCLES, 2, cycles of all cs_n high between bursts (>=1).
- TIMEOUT_CYCLES, 256, max cycles from spi_load to spi_done (fits 16 bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  per-requester request; held high while req_data/req_last are valid.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_last  in  NUM_REQ  byte is the last of the burst.
- req_ack  out  NUM_REQ  one-cycle pulse: granted requester's byte was shifted out.
- spi_load  out  1  one-cycle pulse to the byte engine's load input.
- spi_data_out  out  8  byte to the engine; stable from spi_load until spi_done.
- spi_done  in  1  engine completion pulse.
- cs_n  out  NUM_REQ  chip selects, active low, at most one low.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current/last granted requester.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset values:
  - req_ack=0, spi_load=0, spi_data_out=0, cs_n=all 1, busy=0, timeout_err=0, grant_id=0.
  - Internal last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer aborts immediately with no ack. The byte engine shares the same reset.
- All outputs are registered.
- States and transitions:
  - IDLE: if any req is high, grant the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap. Record g, drive cs_n[g]=0, go to CS_SETUP.
  - CS_SETUP: count CS_SETUP_CYCLES cycles, then go to LOAD.
  - LOAD: one cycle. Latch req_data[g] and req_last[g]; the next cycle spi_load=1 and spi_data_out=latched byte. Go to WAIT_DONE.
  - WAIT_DONE: the watchdog counter starts at the spi_load cycle.
    - On spi_done: req_ack[g] pulses the following cycle. If the latched last flag is set, go to CS_HOLD; otherwise go to BYTE_GAP.
    - If the counter reaches TIMEOUT_CYCLES first: set timeout_err, no ack, go to CS_HOLD.
  - BYTE_GAP: one cycle, coincident with the req_ack pulse. The requester updates data during this cycle. If req[g]=1, go to LOAD and keep cs_n low; if req[g]=0 (burst abandoned), go to CS_HOLD.
  - CS_HOLD: CS_HOLD_CYCLES cycles with cs_n[g] low, then cs_n all high, last_grant=g, go to GAP. When entered from the last byte, req_ack[g] pulses in the first CS_HOLD cycle.
  - GAP: GAP_CYCLES cycles, then IDLE. req is not sampled in GAP.
- Bursts are never pre-empted; arbitration happens only in IDLE.
- spi_done outside WAIT_DONE is ignored.
- A req deasserted during CS_SETUP is ignored; the latched byte is still sent in LOAD.
- Requesters must drop req in the cycle after the final ack, otherwise they are re-granted under round-robin.
- Minimum gap between consecutive spi_load pulses in a burst is 3 cycles. This satisfies the byte engine, which accepts a load only after returning to its idle state.
- Counters are saturating and sized by $clog2 of their parameter.

Decomposition:
- Package spi_arb_pkg:
  - State enum: IDLE, CS_SETUP, LOAD, WAIT_DONE, BYTE_GAP, CS_HOLD, GAP.
  - Width constants for the timing counters and grant index.
- Sub-module rr_arbiter (NUM_REQ param): combinational round-robin pick from req and last_grant, giving a one-hot grant and index. Reused by future shared-peripheral blocks.

Test Plan:
- Single byte: req[1]=1, req_data[1]=8'hA5, last=1.
  - Expect cs_n=4'b1101 after 1 cycle.
  - spi_load 5 cycles after cs_n falls (CS_SETUP=4, LOAD=1), spi_data_out=8'hA5.
  - Engine shifts A5 MSB first; req_ack[1] pulses once.
  - cs_n high 4 cycles after the ack; busy low after the 2 GAP cycles.
- Burst: requester 0 sends 8'h11, 8'h22, 8'h33 (last on 8'h33).
  - Expect cs_n[0] low continuously, 3 spi_load pulses and 3 acks, MOSI bytes in order 11, 22, 33.
- Round-robin: req=4'b1111 held with single-byte transfers.
  - Grant order 0,1,2,3,0; all cs_n high for >=2 cycles between bursts.
- Timeout: TIMEOUT_CYCLES=16 with spi_done tied low.
  - Expect timeout_err=1 at 16 cycles after spi_load, no req_ack, cs_n released after hold; timeout_err stays 1 until reset.
- Abandoned burst: req[2] drops during BYTE_GAP after the first byte (last=0).
  - Expect CS_HOLD then release; only 1 ack.
- Reset mid-WAIT_DONE: assert reset for 1 cycle.
  - Next cycle cs_n=all 1, spi_load=0, busy=0, no ack; a subsequent req[3] is granted normally.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI transmitter arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StLoad,
    StWaitDone,
    StByteGap,
    StCsHold,
    StGap
  } arb_state_e;

  // grant_id is exported at a fixed width so NUM_REQ up to 8 fits.
  localparam int unsigned GRANT_W = 3;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Requester and byte-engine handshake bundle around the SPI transmit arbiter.
interface spi_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 spi_load;
  logic [7:0]           spi_data_out;
  logic                 spi_done;
  logic [NUM_REQ-1:0]   cs_n;

  modport master (
    input  req, req_data, req_last, spi_done,
    output req_ack, spi_load, spi_data_out, cs_n
  );

  modport slave (
    output req, req_data, req_last, spi_done,
    input  req_ack, spi_load, spi_data_out, cs_n
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  int unsigned cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ($clog2(NUM_REQ))'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one SPI byte engine among NUM_REQ requesters with round-robin grant,
// per-requester chip select timing, multi-byte bursts and a done watchdog.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned CS_SETUP_CYCLES = 4,
  parameter int unsigned CS_HOLD_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic               clk,
  input  logic               reset,
  spi_tx_arbiter_if.master   bus,
  output logic               busy,
  output logic [GRANT_W-1:0] grant_id,
  output logic               timeout_err
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned TIME_W = max_u(cnt_width(CS_SETUP_CYCLES),
                                         max_u(cnt_width(CS_HOLD_CYCLES),
                                               cnt_width(GAP_CYCLES)));
  localparam int unsigned WD_W   = cnt_width(TIMEOUT_CYCLES);

  localparam logic [TIME_W-1:0] SetupLast = TIME_W'(CS_SETUP_CYCLES - 1);
  localparam logic [TIME_W-1:0] HoldLast  = TIME_W'(CS_HOLD_CYCLES - 1);
  localparam logic [TIME_W-1:0] GapLast   = TIME_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]   WdLast    = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [TIME_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
  logic               load_q, load_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (bus.req),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    last_d       = last_q;
    ack_d        = '0;
    cs_n_d       = cs_n_q;
    load_d       = 1'b0;
    data_d       = data_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          cs_n_d  = ~arb_grant;
          cnt_d   = '0;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StLoad;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StLoad: begin
        // The driven byte doubles as the latch; it holds until the next LOAD.
        data_d  = bus.req_data[{grant_q, 3'b000} +: 8];
        last_d  = bus.req_last[grant_q];
        load_d  = 1'b1;
        wd_d    = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.spi_done) begin
          ack_d[grant_q] = 1'b1;
          cnt_d          = '0;
          state_d        = last_q ? StCsHold : StByteGap;
        end else if (wd_q == WdLast) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = StCsHold;
        end else begin
          wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        end
      end
      StByteGap: begin
        if (bus.req[grant_q]) begin
          state_d = StLoad;
        end else begin
          cnt_d   = '0;
          state_d = StCsHold;
        end
      end
      StCsHold: begin
        if (cnt_q == HoldLast) begin
          cs_n_d       = '1;
          last_grant_d = grant_q;
          cnt_d        = '0;
          state_d      = StGap;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: begin
        cs_n_d  = '1;
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wd_q         <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      last_q       <= 1'b0;
      ack_q        <= '0;
      cs_n_q       <= '1;
      load_q       <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      ack_q        <= ack_d;
      cs_n_q       <= cs_n_d;
      load_q       <= load_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.req_ack      = ack_q;
  assign bus.spi_load     = load_q;
  assign bus.spi_data_out = data_q;
  assign bus.cs_n         = cs_n_q;
  assign busy             = busy_q;
  assign grant_id         = GRANT_W'(grant_q);
  assign timeout_err      = tmo_q;

endmodule
